// File: rtl/cond_seq_pkg.sv
// Shared types and default parameters for the condition sequencer.
package cond_seq_pkg;

  localparam int N_COND_DEF  = 4;
  localparam int TMO_W_DEF   = 8;
  localparam int TMO_MAX_DEF = 200;

  // Sequencer state encodings; the remaining 3-bit codes are illegal.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_ARMED    = 3'b001,
    ST_PARTIAL  = 3'b010,
    ST_COMPLETE = 3'b011,
    ST_DONE     = 3'b100,
    ST_TIMEOUT  = 3'b101
  } state_e;

endpackage

// File: rtl/cond_tracker.sv
// Sticky record of observed condition channels plus its popcount.
module cond_tracker
  import cond_seq_pkg::*;
#(
  parameter int N_COND = N_COND_DEF,
  parameter int CNT_W  = $clog2(N_COND + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_COND-1:0] cond,
  input  logic              clear,
  output logic [N_COND-1:0] seen,
  output logic [CNT_W-1:0]  seen_cnt
);

  logic [N_COND-1:0] r_seen;
  logic [CNT_W-1:0]  w_cnt;

  // Accumulate condition bits; clear wipes the mask and drops same-cycle cond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen <= {N_COND{1'b0}};
    end else if (clear) begin
      r_seen <= {N_COND{1'b0}};
    end else begin
      r_seen <= r_seen | cond;
    end
  end

  // Count set bits of the registered mask (no extra latency).
  always_comb begin
    w_cnt = {CNT_W{1'b0}};
    for (int i = 0; i < N_COND; i++) begin
      w_cnt = w_cnt + CNT_W'(r_seen[i]);
    end
  end

  assign seen     = r_seen;
  assign seen_cnt = w_cnt;

endmodule

// File: rtl/cond_sequencer.sv
// Condition sequencer: arms on start, waits for all channels or a timeout.
module cond_sequencer
  import cond_seq_pkg::*;
#(
  parameter int N_COND  = N_COND_DEF,
  parameter int TMO_W   = TMO_W_DEF,
  parameter int TMO_MAX = TMO_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_COND-1:0]            cond,
  input  logic                         start,
  input  logic                         clear,
  output logic [N_COND-1:0]            seen,
  output logic [$clog2(N_COND+1)-1:0]  seen_cnt,
  output logic [2:0]                   state_code,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout
);

  localparam int               CNT_W    = $clog2(N_COND + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_e            r_state;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;

  state_e            w_next;
  logic [TMO_W-1:0]  w_tmo_next;
  logic [N_COND-1:0] w_seen;
  logic              w_complete;
  logic              w_any;
  logic              w_tmo_last;
  logic              w_in_win;
  logic              w_next_in_win;

  cond_tracker #(
    .N_COND (N_COND),
    .CNT_W  (CNT_W)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .clear    (clear),
    .seen     (w_seen),
    .seen_cnt (seen_cnt)
  );

  // The sequencer only looks at the registered mask, never at raw cond.
  assign w_complete    = &w_seen;
  assign w_any         = |w_seen;
  assign w_tmo_last    = (r_tmo_cnt == TMO_LAST);
  assign w_in_win      = (r_state == ST_ARMED) || (r_state == ST_PARTIAL);
  assign w_next_in_win = (w_next == ST_ARMED) || (w_next == ST_PARTIAL);

  // Next-state selection; clear overrides everything, completion beats timeout.
  always_comb begin
    w_next = ST_IDLE;
    if (clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!start)          w_next = ST_IDLE;
          else if (!w_any)     w_next = ST_ARMED;
          else if (w_complete) w_next = ST_COMPLETE;
          else                 w_next = ST_PARTIAL;
        end
        ST_ARMED: begin
          if (w_complete)      w_next = ST_COMPLETE;
          else if (w_tmo_last) w_next = ST_TIMEOUT;
          else if (w_any)      w_next = ST_PARTIAL;
          else                 w_next = ST_ARMED;
        end
        ST_PARTIAL: begin
          if (w_complete)      w_next = ST_COMPLETE;
          else if (w_tmo_last) w_next = ST_TIMEOUT;
          else                 w_next = ST_PARTIAL;
        end
        ST_COMPLETE: w_next = ST_DONE;
        ST_DONE:     w_next = ST_DONE;
        ST_TIMEOUT:  w_next = ST_TIMEOUT;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // Timer runs across ARMED and PARTIAL without restarting, else held at zero.
  always_comb begin
    w_tmo_next = {TMO_W{1'b0}};
    if (w_next_in_win && w_in_win) begin
      w_tmo_next = r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      w_tmo_next = {TMO_W{1'b0}};
    end
  end

  // State, timer and registered Moore flags, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= {TMO_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tmo_cnt <= w_tmo_next;
      r_busy    <= w_next_in_win || (w_next == ST_COMPLETE);
      r_done    <= (w_next == ST_DONE);
      r_timeout <= (w_next == ST_TIMEOUT);
    end
  end

  assign seen       = w_seen;
  assign state_code = r_state;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_cond_sequencer.sv
// Directed scoreboard bench for cond_sequencer (N_COND=4, TMO_MAX=8).
module tb_cond_sequencer;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_ARM  = 3'b001;
  localparam logic [2:0] S_PART = 3'b010;
  localparam logic [2:0] S_CMP  = 3'b011;
  localparam logic [2:0] S_DONE = 3'b100;
  localparam logic [2:0] S_TMO  = 3'b101;

  typedef struct {
    logic [2:0] st;
    logic [3:0] seen;
    string      tag;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] cond;
  logic       start;
  logic       clear;
  logic [3:0] seen;
  logic [2:0] seen_cnt;
  logic [2:0] state_code;
  logic       busy;
  logic       done;
  logic       timeout;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  cond_sequencer #(
    .N_COND  (4),
    .TMO_W   (8),
    .TMO_MAX (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .start      (start),
    .clear      (clear),
    .seen       (seen),
    .seen_cnt   (seen_cnt),
    .state_code (state_code),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_out();
    exp_t       e;
    logic       eb;
    logic [2:0] ec;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e  = sb.pop_front();
      eb = (e.st == S_ARM) || (e.st == S_PART) || (e.st == S_CMP);
      ec = 3'($countones(e.seen));
      chk({e.tag, "_state"}, 8'(state_code), 8'(e.st));
      chk({e.tag, "_seen"},  8'(seen),       8'(e.seen));
      chk({e.tag, "_cnt"},   8'(seen_cnt),   8'(ec));
      chk({e.tag, "_busy"},  8'(busy),       8'(eb));
      chk({e.tag, "_done"},  8'(done),       8'(e.st == S_DONE));
      chk({e.tag, "_tmo"},   8'(timeout),    8'(e.st == S_TMO));
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge result, then check.
  task automatic cyc(input logic [3:0] c, input logic s, input logic cl,
                     input logic [2:0] es, input logic [3:0] ev, input string tag);
    exp_t e;
    cond  = c;
    start = s;
    clear = cl;
    e.st   = es;
    e.seen = ev;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cond  = 4'b0000;
    start = 1'b0;
    clear = 1'b0;
    check_out();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 8'(state_code), 8'h00);
    chk({tag, "_seen"},  8'(seen),       8'h00);
    chk({tag, "_cnt"},   8'(seen_cnt),   8'h00);
    chk({tag, "_busy"},  8'(busy),       8'h00);
    chk({tag, "_done"},  8'(done),       8'h00);
    chk({tag, "_tmo"},   8'(timeout),    8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    cond    = 4'b0000;
    start   = 1'b0;
    clear   = 1'b0;
    #12;
    check_zero("rst");
    reset = 1'b0;

    // Ordered arrival
    cyc(4'b0000, 1'b1, 1'b0, S_ARM,  4'b0000, "ord_arm");
    cyc(4'b0001, 1'b0, 1'b0, S_ARM,  4'b0001, "ord_cap");
    cyc(4'b0000, 1'b0, 1'b0, S_PART, 4'b0001, "ord_part");
    cyc(4'b1110, 1'b0, 1'b0, S_PART, 4'b1111, "ord_last");
    cyc(4'b0000, 1'b0, 1'b0, S_CMP,  4'b1111, "ord_cmp");
    cyc(4'b0000, 1'b0, 1'b0, S_DONE, 4'b1111, "ord_done");
    cyc(4'b0000, 1'b1, 1'b0, S_DONE, 4'b1111, "ord_start_ign");
    cyc(4'b0000, 1'b0, 1'b1, S_IDLE, 4'b0000, "ord_clr");

    // Pre-satisfied: all bits before start
    cyc(4'b1111, 1'b0, 1'b0, S_IDLE, 4'b1111, "pre_fill");
    cyc(4'b0000, 1'b1, 1'b0, S_CMP,  4'b1111, "pre_cmp");
    cyc(4'b0000, 1'b0, 1'b0, S_DONE, 4'b1111, "pre_done");
    cyc(4'b0000, 1'b0, 1'b1, S_IDLE, 4'b0000, "pre_clr");

    // Timeout after 8 cycles in ARMED/PARTIAL
    cyc(4'b0000, 1'b1, 1'b0, S_ARM,  4'b0000, "tmo_arm");
    cyc(4'b0011, 1'b0, 1'b0, S_ARM,  4'b0011, "tmo_c1");
    for (int i = 2; i <= 7; i++) begin
      cyc(4'b0000, 1'b0, 1'b0, S_PART, 4'b0011, $sformatf("tmo_p%0d", i));
    end
    cyc(4'b0000, 1'b0, 1'b0, S_TMO,  4'b0011, "tmo_fire");
    cyc(4'b0000, 1'b1, 1'b0, S_TMO,  4'b0011, "tmo_start_ign");
    cyc(4'b0000, 1'b0, 1'b0, S_TMO,  4'b0011, "tmo_hold");
    cyc(4'b0000, 1'b0, 1'b1, S_IDLE, 4'b0000, "tmo_clr");

    // Race: completion seen while timer sits at its last value
    cyc(4'b0000, 1'b1, 1'b0, S_ARM,  4'b0000, "race_arm");
    cyc(4'b0001, 1'b0, 1'b0, S_ARM,  4'b0001, "race_c1");
    for (int i = 2; i <= 6; i++) begin
      cyc(4'b0000, 1'b0, 1'b0, S_PART, 4'b0001, $sformatf("race_p%0d", i));
    end
    cyc(4'b1110, 1'b0, 1'b0, S_PART, 4'b1111, "race_p7");
    cyc(4'b0000, 1'b0, 1'b0, S_CMP,  4'b1111, "race_cmp");
    cyc(4'b0000, 1'b0, 1'b0, S_DONE, 4'b1111, "race_done");
    cyc(4'b0000, 1'b0, 1'b1, S_IDLE, 4'b0000, "race_clr");

    // Clear in PARTIAL drops simultaneous cond; start in PARTIAL ignored
    cyc(4'b0000, 1'b1, 1'b0, S_ARM,  4'b0000, "clr_arm");
    cyc(4'b0010, 1'b0, 1'b0, S_ARM,  4'b0010, "clr_c1");
    cyc(4'b0000, 1'b0, 1'b0, S_PART, 4'b0010, "clr_part");
    cyc(4'b0000, 1'b1, 1'b0, S_PART, 4'b0010, "clr_start_ign");
    cyc(4'b0100, 1'b0, 1'b1, S_IDLE, 4'b0000, "clr_mid");
    cyc(4'b0000, 1'b0, 1'b0, S_IDLE, 4'b0000, "clr_nocap");
    cyc(4'b0000, 1'b1, 1'b1, S_IDLE, 4'b0000, "clr_and_start");

    // Async reset mid-run, then a fresh timeout proves the timer restarted
    cyc(4'b0000, 1'b1, 1'b0, S_ARM,  4'b0000, "ar_arm");
    cyc(4'b0101, 1'b0, 1'b0, S_ARM,  4'b0101, "ar_c1");
    cyc(4'b0000, 1'b0, 1'b0, S_PART, 4'b0101, "ar_part");
    #2;
    reset = 1'b1;
    #1;
    check_zero("ar_async");
    #2;
    reset = 1'b0;
    cyc(4'b0000, 1'b0, 1'b0, S_IDLE, 4'b0000, "ar_idle");
    cyc(4'b0000, 1'b1, 1'b0, S_ARM,  4'b0000, "ar_rearm");
    for (int i = 1; i <= 7; i++) begin
      cyc(4'b0000, 1'b0, 1'b0, S_ARM, 4'b0000, $sformatf("ar_a%0d", i));
    end
    cyc(4'b0000, 1'b0, 1'b0, S_TMO,  4'b0000, "ar_tmo");
    cyc(4'b0000, 1'b0, 1'b1, S_IDLE, 4'b0000, "ar_clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
